tmds_lane_packer: RTL and testbench

//  Upstream feeder for one QSFP HDMI transceiver group. Buffers TMDS symbol beats (4 symbols/channel/beat) in a FIFO.

---
 rtl/tmds_pkg.sv | 25 ++
 rtl/tmds_word_fifo.sv | 57 +++++
 rtl/tmds_lane_packer.sv | 114 +++++++++++
 tb/tb_tmds_lane_packer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants, state encoding and helpers for the TMDS lane packer.
package tmds_pkg;

    localparam int LANE_W       = 40;
    localparam int SYM_W        = 10;
    localparam int SYM_PER_LANE = 4;
    localparam int NUM_LANES    = 4;
    localparam int CLOCK_LANE   = 3;
    localparam int DATA_W       = 120;
    localparam int WORD_W       = LANE_W * NUM_LANES;

    localparam logic [SYM_W-1:0] DEF_CTRL_SYMBOL  = 10'b1101010100;
    localparam logic [SYM_W-1:0] DEF_CLOCK_SYMBOL = 10'b0000011111;

    typedef enum logic {
        ST_FILL,
        ST_RUN
    } state_t;

    // Replicate one symbol across all symbol slots of a lane.
    function automatic logic [LANE_W-1:0] rep_symbol(input logic [SYM_W-1:0] sym);
        return {SYM_PER_LANE{sym}};
    endfunction

endpackage

// File: rtl/tmds_word_fifo.sv
// Synchronous beat FIFO with show-ahead head, push/pop and occupancy output.
// Push when full and pop when empty are ignored.
module tmds_word_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 120,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [LW-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (level < LW'(DEPTH));
    assign do_pop  = pop && (level != '0);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/tmds_lane_packer.sv
// Packs buffered TMDS symbol beats into the 160-bit transceiver word:
// lanes 0-2 carry TMDS ch0-2, lane 3 carries the constant clock pattern.
// Underflow in RUN emits a control word and drops back to FILL.
// Optional macro TMDS_LANE_INVERT_EN adds per-lane output inversion.
module tmds_lane_packer
    import tmds_pkg::*;
#(
    parameter int               FIFO_DEPTH   = 16,
    parameter int               START_LEVEL  = 8,
    parameter logic [SYM_W-1:0] CTRL_SYMBOL  = DEF_CTRL_SYMBOL,
    parameter logic [SYM_W-1:0] CLOCK_SYMBOL = DEF_CLOCK_SYMBOL
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_W-1:0]             in_data,
`ifdef TMDS_LANE_INVERT_EN
    input  logic [NUM_LANES-1:0]          lane_invert,
`endif
    output logic [WORD_W-1:0]             tx_data,
    output logic                          streaming,
    output logic [15:0]                   underflow_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [LANE_W-1:0] CTRL_LANE  = rep_symbol(CTRL_SYMBOL);
    localparam logic [LANE_W-1:0] CLOCK_WORD = rep_symbol(CLOCK_SYMBOL);
    localparam logic [DATA_W-1:0] CTRL_DATA  = {3{CTRL_LANE}};
    localparam logic [WORD_W-1:0] IDLE_WORD  = {CLOCK_WORD, CTRL_DATA};

    state_t              state;
    state_t              state_next;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                underflow_evt;
    logic [DATA_W-1:0]   head;
    logic [DATA_W-1:0]   data_next;
    logic [WORD_W-1:0]   word_next;

    assign in_ready   = (fifo_level < LW'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_level == '0);

    tmds_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W),
        .LW    (LW)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .level     (fifo_level)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next state: fill to threshold, stream until the FIFO runs dry.
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL: if (fifo_level >= LW'(START_LEVEL)) state_next = ST_RUN;
            ST_RUN:  if (fifo_empty) state_next = ST_FILL;
            default: state_next = ST_FILL;
        endcase
    end

    // Outputs: pop decision, underflow event and the next transmit word.
    always_comb begin
        pop           = (state == ST_RUN) && !fifo_empty;
        underflow_evt = (state == ST_RUN) && fifo_empty;
        streaming     = (state == ST_RUN);
        data_next     = pop ? head : CTRL_DATA;
        word_next     = {{LANE_W{1'b0}}, data_next};
        word_next[CLOCK_LANE*LANE_W +: LANE_W] = CLOCK_WORD;
`ifdef TMDS_LANE_INVERT_EN
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            word_next[l*LANE_W +: LANE_W] = word_next[l*LANE_W +: LANE_W] ^ {LANE_W{lane_invert[l]}};
        end
`endif
    end

    // Output register; reset forces the idle word immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_data <= IDLE_WORD;
        end else begin
            tx_data <= word_next;
        end
    end

    // Saturating count of RUN->FILL underflow events.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            underflow_count <= '0;
        end else if (underflow_evt && (underflow_count != '1)) begin
            underflow_count <= underflow_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_tmds_lane_packer.sv
// Directed self-checking bench for tmds_lane_packer.
module tb_tmds_lane_packer;

    localparam logic [39:0]  CLK_W    = 40'h07C1F07C1F;
    localparam logic [9:0]   CTRL_SYM = 10'b1101010100;
    localparam logic [39:0]  CTRL_L   = {4{CTRL_SYM}};
    localparam logic [159:0] IDLE     = {CLK_W, CTRL_L, CTRL_L, CTRL_L};

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [119:0] in_data = '0;
    logic [159:0] tx_data;
    logic         streaming;
    logic [15:0]  underflow_count;
    logic [4:0]   fifo_level;

    logic         f_valid = 1'b0;
    logic         f_ready;
    logic [119:0] f_data = '0;
    logic [159:0] f_tx;
    logic         f_streaming;
    logic [15:0]  f_count;
    logic [4:0]   f_level;

`ifdef TMDS_LANE_INVERT_EN
    logic [3:0]   lane_invert = 4'b0000;
    logic [3:0]   f_invert = 4'b0000;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    tmds_lane_packer #(
        .FIFO_DEPTH  (16),
        .START_LEVEL (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
`ifdef TMDS_LANE_INVERT_EN
        .lane_invert     (lane_invert),
`endif
        .tx_data         (tx_data),
        .streaming       (streaming),
        .underflow_count (underflow_count),
        .fifo_level      (fifo_level)
    );

    tmds_lane_packer #(
        .FIFO_DEPTH  (16),
        .START_LEVEL (16)
    ) dut_full (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (f_valid),
        .in_ready        (f_ready),
        .in_data         (f_data),
`ifdef TMDS_LANE_INVERT_EN
        .lane_invert     (f_invert),
`endif
        .tx_data         (f_tx),
        .streaming       (f_streaming),
        .underflow_count (f_count),
        .fifo_level      (f_level)
    );

    // Beat with every symbol of chN equal to k+N.
    function automatic logic [119:0] beat_spec(input int k);
        logic [119:0] b;
        for (int ch = 0; ch < 3; ch++)
            for (int j = 0; j < 4; j++)
                b[ch*40 + j*10 +: 10] = 10'(k + ch);
        return b;
    endfunction

    // Beat with a distinct value in every symbol slot.
    function automatic logic [119:0] beat_var(input int k);
        logic [119:0] b;
        for (int ch = 0; ch < 3; ch++)
            for (int j = 0; j < 4; j++)
                b[ch*40 + j*10 +: 10] = 10'(((k & 63) << 4) | (ch << 2) | j);
        return b;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (tx_data[159:120] !== CLK_W) begin failures++; $display("FAIL reset_lane3 got=%h exp=%h", tx_data[159:120], CLK_W); end
        checks++; if (tx_data[119:0] !== IDLE[119:0]) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", tx_data[119:0], IDLE[119:0]); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
        checks++; if (streaming !== 1'b0) begin failures++; $display("FAIL reset_streaming got=%b exp=0", streaming); end
        checks++; if (underflow_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", underflow_count); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (f_tx !== IDLE) begin failures++; $display("FAIL reset_full_tx got=%h exp=%h", f_tx, IDLE); end
    endtask

    task automatic test_prime_underflow();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = beat_spec(k);
            step();
        end
        in_valid = 1'b0;
        checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL prime_level got=%0d exp=8", fifo_level); end
        checks++; if (streaming !== 1'b0) begin failures++; $display("FAIL prime_pre_run got=%b exp=0", streaming); end
        step();
        checks++; if (streaming !== 1'b1) begin failures++; $display("FAIL prime_run got=%b exp=1", streaming); end
        checks++; if (tx_data !== IDLE) begin failures++; $display("FAIL prime_first_ctrl got=%h exp=%h", tx_data, IDLE); end
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (tx_data !== {CLK_W, beat_spec(k)}) begin
                failures++; $display("FAIL prime_beat%0d got=%h exp=%h", k, tx_data, {CLK_W, beat_spec(k)});
            end
        end
        step();
        checks++; if (tx_data !== IDLE) begin failures++; $display("FAIL underflow_ctrl got=%h exp=%h", tx_data, IDLE); end
        checks++; if (underflow_count !== 16'd1) begin failures++; $display("FAIL underflow_count got=%0d exp=1", underflow_count); end
        checks++; if (streaming !== 1'b0) begin failures++; $display("FAIL underflow_streaming got=%b exp=0", streaming); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = beat_var(k);
            step();
        end
        in_valid = 1'b0;
        step();
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1;
            in_data  = beat_var(8 + c);
            step();
            checks++; if (fifo_level !== 5'd8) begin failures++; $display("FAIL b2b_level c=%0d got=%0d exp=8", c, fifo_level); end
            checks++;
            if (tx_data !== {CLK_W, beat_var(c)}) begin
                failures++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, tx_data, {CLK_W, beat_var(c)});
            end
        end
        in_valid = 1'b0;
        for (int c = 100; c < 108; c++) begin
            step();
            checks++;
            if (tx_data !== {CLK_W, beat_var(c)}) begin
                failures++; $display("FAIL b2b_drain c=%0d got=%h exp=%h", c, tx_data, {CLK_W, beat_var(c)});
            end
        end
        step();
        checks++; if (tx_data !== IDLE) begin failures++; $display("FAIL b2b_end_ctrl got=%h exp=%h", tx_data, IDLE); end
        checks++; if (underflow_count !== 16'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", underflow_count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            checks++; if (f_ready !== 1'b1) begin failures++; $display("FAIL full_ready_fill i=%0d got=%b exp=1", i, f_ready); end
            f_valid = 1'b1;
            f_data  = beat_var(i);
            step();
        end
        checks++; if (f_level !== 5'd16) begin failures++; $display("FAIL full_level got=%0d exp=16", f_level); end
        checks++; if (f_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", f_ready); end
        checks++; if (f_streaming !== 1'b0) begin failures++; $display("FAIL full_pre_run got=%b exp=0", f_streaming); end
        f_data = beat_var(16);
        step();
        checks++; if (f_streaming !== 1'b1) begin failures++; $display("FAIL full_run got=%b exp=1", f_streaming); end
        checks++; if (f_ready !== 1'b0) begin failures++; $display("FAIL full_ready_run got=%b exp=0", f_ready); end
        step();
        checks++; if (f_level !== 5'd15) begin failures++; $display("FAIL full_pop_no_push got=%0d exp=15", f_level); end
        checks++; if (f_tx !== {CLK_W, beat_var(0)}) begin failures++; $display("FAIL full_beat0 got=%h exp=%h", f_tx, {CLK_W, beat_var(0)}); end
        f_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            checks++;
            if (f_tx !== {CLK_W, beat_var(i)}) begin
                failures++; $display("FAIL full_drain i=%0d got=%h exp=%h", i, f_tx, {CLK_W, beat_var(i)});
            end
        end
        step();
        checks++; if (f_tx !== IDLE) begin failures++; $display("FAIL full_end_ctrl got=%h exp=%h", f_tx, IDLE); end
        checks++; if (f_count !== 16'd1) begin failures++; $display("FAIL full_count got=%0d exp=1", f_count); end
    endtask

    task automatic test_mid_reset();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = beat_var(200 + k);
            step();
        end
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (tx_data !== {CLK_W, beat_var(200 + k)}) begin
                failures++; $display("FAIL midrst_pre k=%0d got=%h exp=%h", k, tx_data, {CLK_W, beat_var(200 + k)});
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (tx_data !== IDLE) begin failures++; $display("FAIL midrst_async_idle got=%h exp=%h", tx_data, IDLE); end
        checks++; if (underflow_count !== 16'd0) begin failures++; $display("FAIL midrst_count got=%0d exp=0", underflow_count); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", fifo_level); end
        checks++; if (streaming !== 1'b0) begin failures++; $display("FAIL midrst_streaming got=%b exp=0", streaming); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
        step();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = beat_var(300 + k);
            step();
        end
        in_valid = 1'b0;
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (tx_data !== {CLK_W, beat_var(300 + k)}) begin
                failures++; $display("FAIL midrst_post k=%0d got=%h exp=%h", k, tx_data, {CLK_W, beat_var(300 + k)});
            end
        end
        step();
        checks++; if (tx_data !== IDLE) begin failures++; $display("FAIL midrst_end_ctrl got=%h exp=%h", tx_data, IDLE); end
        checks++; if (underflow_count !== 16'd1) begin failures++; $display("FAIL midrst_end_count got=%0d exp=1", underflow_count); end
    endtask

`ifdef TMDS_LANE_INVERT_EN
    task automatic test_lane_invert();
        lane_invert = 4'b1000;
        step();
        checks++; if (tx_data[159:120] !== ~CLK_W) begin failures++; $display("FAIL inv_lane3 got=%h exp=%h", tx_data[159:120], ~CLK_W); end
        checks++; if (tx_data[119:0] !== IDLE[119:0]) begin failures++; $display("FAIL inv_others got=%h exp=%h", tx_data[119:0], IDLE[119:0]); end
        lane_invert = 4'b0000;
        step();
        checks++; if (tx_data !== IDLE) begin failures++; $display("FAIL inv_off got=%h exp=%h", tx_data, IDLE); end
    endtask
`endif

    initial begin
        test_reset();
        test_prime_underflow();
        test_back_to_back();
        test_full();
        test_mid_reset();
`ifdef TMDS_LANE_INVERT_EN
        test_lane_invert();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
